// File: rtl/sdram_init_monitor.sv
`timescale 1ns/1ps
// Purpose: watches the SDRAM power-up command stream, checks order and spacing, captures the mode register.
// Latency: status and mode fields are registered and appear the cycle after the deciding command.
// Backpressure: none; one command is sampled every clock and DONE/ERR are absorbing until reset.
module sdram_init_monitor #(
    parameter int DELAY_200US = 10000,
    parameter int T_RP        = 1,
    parameter int T_RFC       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  cmd_reg,
    input  logic [11:0] sdram_addr,
    output logic        init_done,
    output logic        init_err,
    output logic [2:0]  err_code,
    output logic [2:0]  mode_bl,
    output logic        mode_bt,
    output logic [2:0]  mode_cl,
    output logic        mode_wb
);

    // {CS_n,RAS_n,CAS_n,WE_n} encodings
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    localparam int PW = (DELAY_200US < 1) ? 1 : $clog2(DELAY_200US + 1);

    typedef enum logic [2:0] {
        S_WAIT_PWR,
        S_WAIT_PRE,
        S_WAIT_AR1,
        S_WAIT_AR2,
        S_WAIT_MRS,
        S_DONE,
        S_ERR
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_pwr_cnt;
    logic            w_pwr_ok;
    logic [3:0]      r_dist;
    logic [4:0]      w_dist;
    logic [2:0]      r_err_code;
    logic [2:0]      w_err_code;
    logic            w_accept;
    logic            w_mrs;
    logic [2:0]      r_mode_bl;
    logic            r_mode_bt;
    logic [2:0]      r_mode_cl;
    logic            r_mode_wb;
    logic            w_is_nop;
    logic            w_cl_ok;
    logic            w_unused_addr;

    assign w_pwr_ok = (r_pwr_cnt >= PW'(DELAY_200US));
    // Distance of the current sample from the last accepted command (register holds edges since, minus one)
    assign w_dist   = {1'b0, r_dist} + 5'd1;
    assign w_is_nop = (cmd_reg == CMD_NOP);
    assign w_cl_ok  = (sdram_addr[6:4] == 3'b010) || (sdram_addr[6:4] == 3'b011);
    // Address bits that carry no mode-register field the monitor reports
    assign w_unused_addr = ^{sdram_addr[11], sdram_addr[8:7]};

    // Power-up counter: counts edges since reset, stops once the wait is satisfied
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwr_cnt <= '0;
        end else if (!w_pwr_ok) begin
            r_pwr_cnt <= r_pwr_cnt + 1'b1;
        end
    end

    // Next-state and violation classification for the sampled command
    always_comb begin
        w_next     = r_state;
        w_err_code = 3'd0;
        w_accept   = 1'b0;
        w_mrs      = 1'b0;
        case (r_state)
            // Once the wait is over, WAIT_PWR already judges commands like WAIT_PRE
            S_WAIT_PWR, S_WAIT_PRE: begin
                if (!w_pwr_ok) begin
                    if (!w_is_nop) begin
                        w_next     = S_ERR;
                        w_err_code = 3'd1;
                    end
                end else if (w_is_nop) begin
                    w_next = S_WAIT_PRE;
                end else if (cmd_reg == CMD_PRE) begin
                    if (sdram_addr[10]) begin
                        w_next   = S_WAIT_AR1;
                        w_accept = 1'b1;
                    end else begin
                        w_next     = S_ERR;
                        w_err_code = 3'd3;
                    end
                end else begin
                    w_next     = S_ERR;
                    w_err_code = 3'd2;
                end
            end
            S_WAIT_AR1: begin
                if (cmd_reg == CMD_AR) begin
                    if (w_dist >= 5'(T_RP)) begin
                        w_next   = S_WAIT_AR2;
                        w_accept = 1'b1;
                    end else begin
                        w_next     = S_ERR;
                        w_err_code = 3'd4;
                    end
                end else if (!w_is_nop) begin
                    w_next     = S_ERR;
                    w_err_code = 3'd2;
                end
            end
            S_WAIT_AR2: begin
                if (cmd_reg == CMD_AR) begin
                    if (w_dist >= 5'(T_RFC)) begin
                        w_next   = S_WAIT_MRS;
                        w_accept = 1'b1;
                    end else begin
                        w_next     = S_ERR;
                        w_err_code = 3'd5;
                    end
                end else if (!w_is_nop) begin
                    w_next     = S_ERR;
                    w_err_code = 3'd2;
                end
            end
            S_WAIT_MRS: begin
                if (cmd_reg == CMD_MRS) begin
                    if (w_dist >= 5'(T_RFC)) begin
                        w_accept = 1'b1;
                        w_mrs    = 1'b1;
                        if (w_cl_ok) begin
                            w_next = S_DONE;
                        end else begin
                            w_next     = S_ERR;
                            w_err_code = 3'd6;
                        end
                    end else begin
                        w_next     = S_ERR;
                        w_err_code = 3'd5;
                    end
                end else if (!w_is_nop) begin
                    w_next     = S_ERR;
                    w_err_code = 3'd2;
                end
            end
            S_DONE:  w_next = S_DONE;
            S_ERR:   w_next = S_ERR;
            default: begin
                w_next     = S_ERR;
                w_err_code = 3'd2;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_WAIT_PWR;
        end else begin
            r_state <= w_next;
        end
    end

    // Only the first violation is latched; ERR never leaves so later codes are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_code <= 3'd0;
        end else if ((w_next == S_ERR) && (r_state != S_ERR)) begin
            r_err_code <= w_err_code;
        end
    end

    // Edge distance since last accepted command, saturating so long gaps never wrap to "too early"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dist <= 4'd0;
        end else if (w_accept) begin
            r_dist <= 4'd0;
        end else if (r_dist != 4'd15) begin
            r_dist <= r_dist + 4'd1;
        end
    end

    // Mode register capture on the timing-legal ModeSet, even when its CAS latency is reserved
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_bl <= 3'd0;
            r_mode_bt <= 1'b0;
            r_mode_cl <= 3'd0;
            r_mode_wb <= 1'b0;
        end else if (w_mrs) begin
            r_mode_bl <= sdram_addr[2:0];
            r_mode_bt <= sdram_addr[3];
            r_mode_cl <= sdram_addr[6:4];
            r_mode_wb <= sdram_addr[9];
        end
    end

    assign init_done = (r_state == S_DONE);
    assign init_err  = (r_state == S_ERR);
    assign err_code  = r_err_code;
    assign mode_bl   = r_mode_bl;
    assign mode_bt   = r_mode_bt;
    assign mode_cl   = r_mode_cl;
    assign mode_wb   = r_mode_wb;

endmodule

// File: tb/tb_sdram_init_monitor.sv
`timescale 1ns/1ps
// Bench: two monitors share one command stream; a full-delay instance for the long directed sequences
// and a short-delay instance for randomized sequences. Each is compared against a reference model that
// tracks how many init steps were accepted and when, and derives outputs from those rules.
module tb_sdram_init_monitor;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_AR  = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cmd = 4'b0111;
    logic [11:0] addr = 12'd0;

    logic        d0_done, d0_err, d0_bt, d0_wb;
    logic [2:0]  d0_code, d0_bl, d0_cl;
    logic        d1_done, d1_err, d1_bt, d1_wb;
    logic [2:0]  d1_code, d1_bl, d1_cl;
    logic [12:0] got0, got1;

    always #5 clk = ~clk;

    sdram_init_monitor u_dut0 (
        .clk(clk), .rst(rst), .cmd_reg(cmd), .sdram_addr(addr),
        .init_done(d0_done), .init_err(d0_err), .err_code(d0_code),
        .mode_bl(d0_bl), .mode_bt(d0_bt), .mode_cl(d0_cl), .mode_wb(d0_wb)
    );

    sdram_init_monitor #(.DELAY_200US(24), .T_RP(2), .T_RFC(3)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_reg(cmd), .sdram_addr(addr),
        .init_done(d1_done), .init_err(d1_err), .err_code(d1_code),
        .mode_bl(d1_bl), .mode_bt(d1_bt), .mode_cl(d1_cl), .mode_wb(d1_wb)
    );

    // Observed outputs packed as {done, err, code, bl, bt, cl, wb}
    assign got0 = {d0_done, d0_err, d0_code, d0_bl, d0_bt, d0_cl, d0_wb};
    assign got1 = {d1_done, d1_err, d1_code, d1_bl, d1_bt, d1_cl, d1_wb};

    // Reference model state, index 0 = full-delay instance, 1 = short-delay instance
    int          m_dly[2]  = '{10000, 24};
    int          m_trp[2]  = '{1, 2};
    int          m_trfc[2] = '{4, 3};
    int          m_k[2];
    int          m_tl[2];
    logic        m_done[2];
    logic        m_err[2];
    logic [2:0]  m_code[2];
    logic [11:0] m_mode[2];

    int t;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (sample %0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic [12:0] m_exp(input int i);
        return {m_done[i], m_err[i], m_code[i], m_mode[i][2:0], m_mode[i][3], m_mode[i][6:4], m_mode[i][9]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_k[i] = 0; m_tl[i] = 0; m_done[i] = 1'b0; m_err[i] = 1'b0;
            m_code[i] = 3'd0; m_mode[i] = 12'd0;
        end
        t = 0;
    endtask

    task automatic model_fail(input int i, input logic [2:0] code);
        m_err[i]  = 1'b1;
        m_code[i] = code;
    endtask

    // Step k = number of init commands accepted so far; required order PRE, AR, AR, MRS
    task automatic model_apply(input logic [3:0] c, input logic [11:0] a);
        logic [3:0] want;
        int         gap;
        for (int i = 0; i < 2; i++) begin
            if (!(m_done[i] || m_err[i]) && c != C_NOP) begin
                want = (m_k[i] == 0) ? C_PRE : (m_k[i] == 3) ? C_MRS : C_AR;
                gap  = (m_k[i] == 1) ? m_trp[i] : m_trfc[i];
                if (m_k[i] == 0 && t < m_dly[i]) model_fail(i, 3'd1);
                else if (c != want) model_fail(i, 3'd2);
                else if (m_k[i] == 0 && !a[10]) model_fail(i, 3'd3);
                else if (m_k[i] > 0 && (t - m_tl[i]) < gap) model_fail(i, (m_k[i] == 1) ? 3'd4 : 3'd5);
                else begin
                    m_k[i]++;
                    m_tl[i] = t;
                    if (m_k[i] == 4) begin
                        m_mode[i] = a;
                        if (a[6:4] == 3'd2 || a[6:4] == 3'd3) m_done[i] = 1'b1;
                        else model_fail(i, 3'd6);
                    end
                end
            end
        end
    endtask

    // Drive one sample, let the rising edge take it, then compare at the falling edge
    task automatic cyc(input logic [3:0] c, input logic [11:0] a, input bit do_chk);
        cmd  = c;
        addr = a;
        model_apply(c, a);
        t++;
        @(negedge clk);
        if (do_chk) begin
            check_eq("dut0_cycle", got0, m_exp(0));
            check_eq("dut1_cycle", got1, m_exp(1));
        end
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++)
            cyc(C_NOP, 12'($urandom), (i < 4) || (i >= n - 4) || (i % 1024 == 0));
    endtask

    // Reset asserted mid-cycle to exercise the asynchronous path, released on a falling edge
    task automatic do_reset();
        @(negedge clk);
        cmd = C_NOP;
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst0", got0, 13'd0);
        check_eq("async_rst1", got1, 13'd0);
        @(negedge clk);
        check_eq("rst_hold0", got0, 13'd0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic legal_seq(input logic [11:0] mrs_a);
        nops(10000);
        cyc(C_PRE, 12'h400, 1'b1);
        cyc(C_AR, 12'h000, 1'b1);
        nops(3);
        cyc(C_AR, 12'h000, 1'b1);
        nops(3);
        cyc(C_MRS, mrs_a, 1'b1);
    endtask

    function automatic logic [3:0] rnd_cmd();
        logic [3:0] tbl [6] = '{C_PRE, C_AR, C_MRS, 4'b0011, 4'b0100, 4'b0110};
        return tbl[$urandom_range(0, 5)];
    endfunction

    initial begin
        logic [3:0]  want [4] = '{C_PRE, C_AR, C_AR, C_MRS};
        logic [3:0]  c;
        logic [11:0] a;
        logic [11:0] cl_tbl [3] = '{12'h020, 12'h030, 12'h000};

        model_reset();
        do_reset();

        // Legal full-length stream, then commands after DONE must not change anything
        legal_seq(12'h032);
        check_eq("legal_done", got0, 13'b1_0_000_010_0_011_0);
        for (int i = 0; i < 6; i++) cyc(rnd_cmd(), 12'($urandom), 1'b1);
        check_eq("done_hold", got0, 13'b1_0_000_010_0_011_0);

        // Precharge one cycle before the power-up wait ends
        do_reset();
        nops(9999);
        cyc(C_PRE, 12'h400, 1'b1);
        check_eq("early_cmd", got0, 13'b0_1_001_000_0_000_0);
        nops(3);
        cyc(C_PRE, 12'h400, 1'b1);
        check_eq("err_hold", got0, 13'b0_1_001_000_0_000_0);

        // Reserved CAS latency: error, fields still captured
        do_reset();
        legal_seq(12'h072);
        check_eq("cl_reserved", got0, 13'b0_1_110_010_0_111_0);

        // Reset between AR1 and AR2 discards progress; a fresh full wait is needed
        do_reset();
        nops(10000);
        cyc(C_PRE, 12'h400, 1'b1);
        cyc(C_AR, 12'h000, 1'b1);
        nops(2);
        do_reset();
        nops(9999);
        check_eq("rst_no_done", got0, 13'd0);
        cyc(C_NOP, 12'h000, 1'b1);
        cyc(C_PRE, 12'h400, 1'b1);
        cyc(C_AR, 12'h000, 1'b1);
        nops(3);
        cyc(C_AR, 12'h000, 1'b1);
        nops(3);
        cyc(C_MRS, 12'h032, 1'b1);
        check_eq("rst_then_legal", got0, 13'b1_0_000_010_0_011_0);

        // Second AutoRefresh three cycles after the first
        do_reset();
        nops(10000);
        cyc(C_PRE, 12'h400, 1'b1);
        cyc(C_AR, 12'h000, 1'b1);
        nops(2);
        cyc(C_AR, 12'h000, 1'b1);
        check_eq("trfc_short", got0, 13'b0_1_101_000_0_000_0);

        // Short-delay instance: Precharge without A10, then ModeSet right after Precharge
        do_reset();
        nops(24);
        cyc(C_PRE, 12'h000, 1'b1);
        check_eq("pre_no_a10", got1, 13'b0_1_011_000_0_000_0);
        do_reset();
        nops(24);
        cyc(C_PRE, 12'h400, 1'b1);
        nops(2);
        cyc(C_MRS, 12'h032, 1'b1);
        check_eq("mrs_out_of_order", got1, 13'b0_1_010_000_0_000_0);

        // Randomized sequences around the legal order and timing
        for (int trial = 0; trial < 60; trial++) begin
            do_reset();
            if ($urandom_range(0, 7) == 0) nops($urandom_range(5, 23));
            else nops(24 + $urandom_range(0, 2));
            for (int s = 0; s < 4; s++) begin
                nops($urandom_range(0, 4));
                c = ($urandom_range(0, 7) == 0) ? rnd_cmd() : want[s];
                a = 12'($urandom);
                if (c == C_PRE) a[10] = ($urandom_range(0, 5) != 0);
                if (c == C_MRS && $urandom_range(0, 3) != 0) begin
                    a[6:4] = 3'd0;
                    a = a | cl_tbl[$urandom_range(0, 1)];
                end
                cyc(c, a, 1'b1);
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 1) == 0) cyc(C_NOP, 12'($urandom), 1'b1);
                else cyc(rnd_cmd(), 12'($urandom), 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
